// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO on the UART transmit side.
// Host pushes bytes; the transmitter pops one byte per frame with a one-cycle
// strobe and samples the registered rd_data any time before its next strobe.
// Status outputs (empty/full/almost_full/data_count) are registered from the
// post-update occupancy, so no input reaches an output combinationally.
// Optional feature macro: UART_FIFO_ERR_EN enables sticky overflow/underflow
// flags; without it both ports are tied low and no error flops exist.
module uart_byte_fifo #(
  parameter int ADDR_W    = 8,
  parameter int AFULL_LVL = 2**ADDR_W - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

  if ((AFULL_LVL < 1) || (AFULL_LVL > (2**ADDR_W))) begin : g_bad_afull
    $error("uart_byte_fifo: AFULL_LVL=%0d outside 1..%0d", AFULL_LVL, 2**ADDR_W);
  end

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              empty_q, empty_d;
  logic              full_q,  full_d;
  logic              afull_q, afull_d;

  logic              rd_acc;
  logic              wr_acc;

  // Acceptance: a pop needs data present; a push needs room, or a slot being
  // freed by a pop in the same cycle (only possible when not empty).
  always_comb begin
    rd_acc = rd_en & ~empty_q;
    wr_acc = wr_en & (~full_q | rd_acc);
  end

  // Next-state for pointers, occupancy, read register and status flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    // The array read uses the pre-edge contents, so a same-edge write into the
    // slot being freed (full, pointers equal) cannot corrupt the popped byte.
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
    afull_d = (count_d >= AFULL_CNT);
  end

  // Control and status registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
    end
  end

  // Storage array: no reset on contents; writes suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign full        = full_q;
  assign almost_full = afull_q;
  assign empty       = empty_q;
  assign data_count  = count_q;
  assign rd_data     = rd_data_q;

`ifdef UART_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags, set the cycle after an offending request.
  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q & ~rd_acc);
    unf_d = unf_q | (rd_en & empty_q);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Testbench for uart_byte_fifo: directed scenarios followed by biased random
// traffic, checked against a queue-based reference model via a scoreboard.
module tb_uart_byte_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = 252;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       full;
  logic       almost_full;
  logic [7:0] rd_data;
  logic       empty;
  logic [8:0] data_count;
  logic       overflow;
  logic       underflow;

  uart_byte_fifo #(.ADDR_W(8), .AFULL_LVL(AFULL)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .data_count  (data_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    int         cnt;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] m_rd  = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the reference model advances by the FIFO's rules
  // and the expected post-edge view is queued for the monitor.
  task automatic drive(input bit r, input bit w, input logic [7:0] d, input bit p);
    exp_t e;
    bit   pop_ok;
    bit   push_ok;
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = p;
    if (r) begin
      mq.delete();
      m_rd  = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = p && (mq.size() > 0);
      push_ok = w && ((mq.size() < DEPTH) || pop_ok);
`ifdef UART_FIFO_ERR_EN
      if (w && (mq.size() == DEPTH) && !pop_ok) m_ovf = 1'b1;
      if (p && (mq.size() == 0)) m_unf = 1'b1;
`endif
      if (pop_ok) m_rd = mq.pop_front();
      if (push_ok) mq.push_back(d);
    end
    e.rd  = m_rd;
    e.cnt = mq.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00, 0);
  endtask

  // Monitor: after each edge compare the DUT against the next expected view.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data",     32'(rd_data),     32'(e.rd));
        chk("data_count",  32'(data_count),  32'(e.cnt));
        chk("empty",       32'(empty),       32'(e.cnt == 0));
        chk("full",        32'(full),        32'(e.cnt == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(e.cnt >= AFULL));
        chk("overflow",    32'(overflow),    32'(e.ovf));
        chk("underflow",   32'(underflow),   32'(e.unf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    int pr;
    int waited;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

    // Reset then idle.
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    idle(10);

    // Two pushes, two strobes five cycles apart; rd_data must hold between.
    drive(0, 1, 8'hA5, 0);
    drive(0, 1, 8'h3C, 0);
    drive(0, 0, 8'h00, 1);
    idle(4);
    drive(0, 0, 8'h00, 1);
    idle(2);

    // Fill completely, attempt a 257th push, drain in order.
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(i), 0);
    drive(0, 1, 8'h77, 0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 8'h00, 1);
    idle(1);

    // Refill, then simultaneous push+pop while full across pointer wrap.
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(i ^ 8'h5C), 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'(8'hE0 + i), 1);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 8'h00, 1);
    idle(1);

    // Empty: push and pop together -> only push accepted.
    drive(0, 1, 8'h5A, 1);
    idle(1);
    drive(0, 0, 8'h00, 1);
    idle(1);

    // Fill to 100 then reset with a push pending.
    for (int i = 0; i < 100; i++) drive(0, 1, 8'($urandom), 0);
    drive(1, 1, 8'hC3, 0);
    idle(2);
    drive(0, 0, 8'h00, 1);
    idle(1);

    // Biased random traffic: phases favour filling, draining or balance.
    for (int ph = 0; ph < 20; ph++) begin
      case ($urandom_range(0, 3))
        0:       begin pw = 85; pr = 15; end
        1:       begin pw = 15; pr = 85; end
        2:       begin pw = 95; pr = 95; end
        default: begin pw = 50; pr = 50; end
      endcase
      for (int c = 0; c < 200; c++) begin
        drive(($urandom_range(0, 999) == 0),
              ($urandom_range(0, 99) < pw),
              8'($urandom),
              ($urandom_range(0, 99) < pr));
      end
    end
    idle(2);

    waited = 0;
    while ((exp_q.size() > 0) && (waited < 10)) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
